// File: rtl/wb_pkg.sv
// Shared widths, constants and entry type for the regfile writeback queue.
package wb_pkg;

    localparam int WORD_DEFAULT = 64;
    localparam int REG_ADDR_W   = 5;

    // Writes to the zero register are architecturally void and never queued.
    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]   regnum;
        logic [WORD_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_fifo.sv
// In-order circular store of pending writebacks; every slot and its validity
// are exposed so the top level can run the forwarding search.
module writeback_fifo
    import wb_pkg::*;
#(
    parameter int WORD  = WORD_DEFAULT,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_reg,
    input  logic [WORD-1:0]       i_data,
    input  logic                  i_pop,
    output logic [CNT_W-1:0]      o_count,
    output logic [PTR_W-1:0]      o_head,
    output logic [REG_ADDR_W-1:0] o_entry_reg  [DEPTH],
    output logic [WORD-1:0]       o_entry_data [DEPTH],
    output logic [DEPTH-1:0]      o_entry_valid
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] regnum;
        logic [WORD-1:0]       data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // NOTE: the storage array has no reset; slot validity comes only from head and count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= '{regnum: i_reg, data: i_data};
        end
    end

    // NOTE: non-blocking updates let push and pop read the same pre-edge pointers and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        o_entry_valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            o_entry_valid[j] = {1'b0, PTR_W'(j) - r_head} < r_count;
            o_entry_reg[j]   = r_mem[j].regnum;
            o_entry_data[j]  = r_mem[j].data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset)
                                     !(i_push && !i_pop && r_count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                                     !(i_pop && r_count == '0));
    a_count_range:  assert property (@(posedge clk) disable iff (reset)
                                     r_count <= CNT_W'(DEPTH));

endmodule

// File: rtl/writeback_queue.sv
// Buffers execute/memory writebacks, drains one per clock onto the regfile
// write port and forwards the youngest pending value to readers.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int WORD  = WORD_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_W-1:0]   in_register,
    input  logic [WORD-1:0]         in_data,
    input  logic                    drain_en,
    output logic [REG_ADDR_W-1:0]   write_register,
    output logic [WORD-1:0]         write_data,
    output logic                    reg_write,
    input  logic [REG_ADDR_W-1:0]   fwd_reg1,
    input  logic [REG_ADDR_W-1:0]   fwd_reg2,
    output logic                    fwd_hit1,
    output logic [WORD-1:0]         fwd_data1,
    output logic                    fwd_hit2,
    output logic [WORD-1:0]         fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            hit;
        logic [WORD-1:0] data;
    } fwd_t;

    logic [CNT_W-1:0]      w_count;
    logic [PTR_W-1:0]      w_head;
    logic [REG_ADDR_W-1:0] w_entry_reg  [DEPTH];
    logic [WORD-1:0]       w_entry_data [DEPTH];
    logic [DEPTH-1:0]      w_entry_valid;
    logic [PTR_W-1:0]      w_age_idx    [DEPTH];
    logic                  w_push;
    logic                  w_pop;
    fwd_t                  w_fwd1;
    fwd_t                  w_fwd2;

    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_register;
    logic [WORD-1:0]       r_write_data;

    // Readiness looks only at the registered count, so a full queue stalls even while draining.
    assign in_ready = w_count < CNT_W'(DEPTH);
    assign w_push   = in_valid && in_ready && (in_register != XZR);
    assign w_pop    = (w_count != '0) && drain_en;

    writeback_fifo #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_push),
        .i_reg         (in_register),
        .i_data        (in_data),
        .i_pop         (w_pop),
        .o_count       (w_count),
        .o_head        (w_head),
        .o_entry_reg   (w_entry_reg),
        .o_entry_data  (w_entry_data),
        .o_entry_valid (w_entry_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else begin
            r_reg_write <= w_pop;
            if (w_pop) begin
                r_write_register <= w_entry_reg[w_head];
                r_write_data     <= w_entry_data[w_head];
            end
        end
    end

    // Physical slot of the i-th oldest entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign w_age_idx[i] = w_head + PTR_W'(i);
    end

    // Scan oldest to youngest so a later match overrides; the output register ranks below all queued entries.
    function automatic fwd_t lookup(input logic [REG_ADDR_W-1:0] r);
        fwd_t res;
        res = '0;
        if (r != XZR) begin
            if (r_reg_write && r_write_register == r) begin
                res.hit  = 1'b1;
                res.data = r_write_data;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_entry_valid[w_age_idx[i]] && w_entry_reg[w_age_idx[i]] == r) begin
                    res.hit  = 1'b1;
                    res.data = w_entry_data[w_age_idx[i]];
                end
            end
        end
        return res;
    endfunction

    // NOTE: each lookup result is fully assigned on every pass, so no latch is inferred.
    always_comb begin
        w_fwd1 = lookup(fwd_reg1);
        w_fwd2 = lookup(fwd_reg2);
    end

    assign fwd_hit1       = w_fwd1.hit;
    assign fwd_data1      = w_fwd1.data;
    assign fwd_hit2       = w_fwd2.hit;
    assign fwd_data2      = w_fwd2.data;
    assign reg_write      = r_reg_write;
    assign write_register = r_write_register;
    assign write_data     = r_write_data;
    assign count          = w_count;

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side producer for the decode-stage register file.
- Accepts register-writeback requests (destination, data) from execute/memory over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one request per clock onto the regfile write port (write_register, write_data, reg_write).
- Provides a forwarding lookup so readers see values still queued or in flight.

Parameters:
- WORD, 64, datapath width of write_data and forwarded data.
- DEPTH, 4, queue entries; power of two, 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  writeback request present.
- in_ready  output  1  queue can accept this cycle.
- in_register  input  5  destination register number.
- in_data  input  WORD  value to write.
- drain_en  input  1  permits popping the head this cycle.
- write_register  output  5  to regfile write_register.
- write_data  output  WORD  to regfile write_data.
- reg_write  output  1  to regfile reg_write.
- fwd_reg1  input  5  lookup register, port 1.
- fwd_reg2  input  5  lookup register, port 2.
- fwd_hit1  output  1  fwd_reg1 has a pending write.
- fwd_data1  output  WORD  youngest pending value for fwd_reg1.
- fwd_hit2  output  1  fwd_reg2 has a pending write.
- fwd_data2  output  WORD  youngest pending value for fwd_reg2.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high.
- Reset values:
  - Queue emptied, pointers 0, count=0.
  - reg_write=0, write_register=0, write_data=0.
  - in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation discards all queued entries and the in-flight output; nothing is written to the regfile in the cycle after reset.
- Handshake:
  - Transfer occurs on an edge with in_valid && in_ready.
  - in_ready = (count < DEPTH), derived from registered count only.
  - in_ready does not depend on a pop in the same cycle, so a full queue refuses input even while draining.
- XZR: a transfer with in_register==31 completes the handshake but is discarded (not enqueued, count unchanged).
- Pop:
  - On each edge, if count>0 && drain_en, the head loads the output registers: reg_write<=1, write_register<=head.reg, write_data<=head.data.
  - Otherwise reg_write<=0; write_register and write_data hold their previous values.
- Latency: an entry accepted at edge k can appear on the write port no earlier than after edge k+1. There is no enqueue-to-output bypass on the same edge.
- Simultaneous push and pop: both take effect; count is unchanged and pointers both advance.
- Ordering:
  - Strict FIFO.
  - Pointers wrap modulo DEPTH.
  - count saturates at neither end; reaching DEPTH+1 or going below 0 is impossible by construction, and an assertion flags it in simulation.
- Forwarding (combinational):
  - Searches the queued entries plus the output register when reg_write=1.
  - Youngest match wins. Priority from highest: newest queue entry, older queue entries, head, then output register.
  - fwd_regN==31 never hits.
  - On a miss, fwd_dataN=0.
- Writes are never reordered, merged or dropped except for register 31.

Decomposition:
- Shared package wb_pkg:
  - WORD default and REG_ADDR_W=5.
  - XZR=5'd31.
  - typedef struct packed {logic [4:0] reg; logic [WORD-1:0] data;} wb_entry_t.
- Sub-module writeback_fifo: storage array, head/tail pointers, count, push/pop.
  - Exposes every entry plus a per-entry valid vector for the forwarding search.
- Top-level owns the output registers, the XZR filter and the forward muxes.

Test Plan:
- Reset then idle:
  - Required: count=0, in_ready=1, reg_write=0, fwd_hit1=0 for fwd_reg1=5.
- Single write:
  - Stimulus: push reg 15 = -354 with drain_en=0; hold 2 cycles; then drain_en=1.
  - Required: fwd_hit1=1 and fwd_data1=-354 while queued; reg_write=1 with write_register=15 for exactly one cycle after the first enabled edge; count back to 0.
- Fill and backpressure:
  - Stimulus: push regs 1,2,3,4 (data 10,20,30,40) with drain_en=0.
  - Required: in_ready=0 and count=4. A fifth push with data 50 stalls. After drain_en=1, outputs follow 10,20,30,40,50 in order.
- Same-register priority:
  - Stimulus: push reg 0 = 55, then reg 0 = 256.
  - Required: fwd_reg2=0 gives fwd_data2=256. After the first pop, fwd_data2 is still 256. After both pops with drain_en then 0, fwd_hit2=0.
- XZR discard:
  - Stimulus: push reg 31 = 23456.
  - Required: handshake completes, count stays 0, reg_write never asserts, fwd_reg1=31 gives hit=0.
- Reset mid-operation:
  - Stimulus: 3 entries queued, reset high one cycle.
  - Required: count=0, reg_write=0 on the next cycle, and no queued data is ever written afterward.
